// File: rtl/router_pkg.sv
// Shared flit/port encodings for the mesh router input path.
package router_pkg;

    localparam int TYPE_W = 2;

    localparam logic [1:0] FLIT_BODY   = 2'b00;
    localparam logic [1:0] FLIT_HEAD   = 2'b01;
    localparam logic [1:0] FLIT_TAIL   = 2'b10;
    localparam logic [1:0] FLIT_SINGLE = 2'b11;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_EAST  = 3'd2;
    localparam logic [2:0] PORT_SOUTH = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    typedef enum logic {
        LK_IDLE = 1'b0,
        LK_BUSY = 1'b1
    } lock_e;

    function automatic int type_msb(input int data_w);
        return data_w - 1;
    endfunction

    function automatic int type_lsb(input int data_w);
        return data_w - TYPE_W;
    endfunction

    // HEAD and SINGLE both carry a destination and start a new route.
    function automatic logic opens_route(input logic [1:0] t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/router_vc_fifo.sv
// Single virtual-channel flit buffer with occupancy count.
module router_vc_fifo #(
    parameter int DATA_W = 35,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_ok, rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    // Storage needs no reset; the count gates everything read out.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/router_vc_input_unit.sv
// Router input port: per-VC buffering, XY routing of head flits,
// packet locking and sticky protocol-error flag.
module router_vc_input_unit
    import router_pkg::*;
#(
    parameter int DATA_W  = 35,
    parameter int NUM_VC  = 2,
    parameter int DEPTH   = 4,
    parameter int COORD_W = 2,
    localparam int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [DATA_W-1:0]        IDATA,
    input  logic                     IVALID,
    input  logic [VCW-1:0]           IVCH,
    output logic [NUM_VC-1:0]        OACK,
    output logic [NUM_VC-1:0]        ORDY,
    output logic [NUM_VC-1:0]        OLCK,
    output logic [NUM_VC*DATA_W-1:0] ODATA,
    output logic [NUM_VC-1:0]        OVALID,
    output logic [NUM_VC*3-1:0]      OROUTE,
    input  logic [NUM_VC-1:0]        IPOP,
    input  logic [COORD_W-1:0]       MY_XPOS,
    input  logic [COORD_W-1:0]       MY_YPOS,
    output logic                     OERR
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TL = type_lsb(DATA_W);

    logic [NUM_VC-1:0] sel, wr_en, rd_en, full, empty, opens;
    logic [DATA_W-1:0] front   [NUM_VC];
    logic [CW-1:0]     count   [NUM_VC];
    logic [2:0]        head_rt [NUM_VC];
    logic [2:0]        route_q [NUM_VC];
    logic [2:0]        route_d [NUM_VC];
    lock_e             lock_q  [NUM_VC];
    lock_e             lock_d  [NUM_VC];
    logic [NUM_VC-1:0] ack_q, ack_d;
    logic              err_q, err_d;
    logic              vc_ok;
    logic [1:0]        in_type;

    function automatic logic [2:0] xy_route(
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] mx,
        input logic [COORD_W-1:0] my
    );
        logic [2:0] rt;
        if (dx > mx)      rt = PORT_EAST;
        else if (dx < mx) rt = PORT_WEST;
        else if (dy > my) rt = PORT_SOUTH;
        else if (dy < my) rt = PORT_NORTH;
        else              rt = PORT_LOCAL;
        return rt;
    endfunction

    assign vc_ok   = (32'(IVCH) < NUM_VC);
    assign in_type = IDATA[TL +: TYPE_W];
    assign OACK    = ack_q;
    assign OERR    = err_q;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign sel[v]     = IVALID && vc_ok && (IVCH == VCW'(v));
        assign wr_en[v]   = sel[v] && !full[v];
        assign rd_en[v]   = IPOP[v] && !empty[v];
        assign ORDY[v]    = (count[v] != CW'(DEPTH));
        assign OVALID[v]  = !empty[v];
        assign OLCK[v]    = (lock_q[v] == LK_BUSY);
        assign opens[v]   = opens_route(front[v][TL +: TYPE_W]);
        assign head_rt[v] = xy_route(front[v][2*COORD_W-1:COORD_W],
                                     front[v][COORD_W-1:0],
                                     MY_XPOS, MY_YPOS);

        assign ODATA[v*DATA_W +: DATA_W] = empty[v] ? '0 : front[v];
        assign OROUTE[v*3 +: 3] = empty[v] ? 3'd0 :
                                  (opens[v] ? head_rt[v] : route_q[v]);

        router_vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (RST),
            .wr_en   (wr_en[v]),
            .wr_data (IDATA),
            .rd_en   (rd_en[v]),
            .rd_data (front[v]),
            .count   (count[v]),
            .full    (full[v]),
            .empty   (empty[v])
        );
    end

    always_comb begin
        ack_d = wr_en;
        err_d = err_q;
        // Anything offered but not written was dropped.
        if (IVALID && !(|wr_en)) err_d = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            lock_d[v]  = lock_q[v];
            route_d[v] = route_q[v];
            if (rd_en[v] && opens[v]) route_d[v] = head_rt[v];
            if (wr_en[v]) begin
                unique case (in_type)
                    FLIT_HEAD: begin
                        if (lock_q[v] == LK_BUSY) err_d = 1'b1;
                        lock_d[v] = LK_BUSY;
                    end
                    FLIT_SINGLE: begin
                        if (lock_q[v] == LK_BUSY) err_d = 1'b1;
                    end
                    FLIT_BODY: begin
                        if (lock_q[v] == LK_IDLE) err_d = 1'b1;
                    end
                    FLIT_TAIL: begin
                        if (lock_q[v] == LK_IDLE) err_d = 1'b1;
                        lock_d[v] = LK_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ack_q <= '0;
            err_q <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                lock_q[v]  <= LK_IDLE;
                route_q[v] <= '0;
            end
        end else begin
            ack_q <= ack_d;
            err_q <= err_d;
            for (int v = 0; v < NUM_VC; v++) begin
                lock_q[v]  <= lock_d[v];
                route_q[v] <= route_d[v];
            end
        end
    end

endmodule
